// File: rtl/change_dispenser.sv
// Change payout sequencer: pays an amount (50-won units) greedily from 1000/500/100/50 inventories,
// one handshaked hopper drop at a time, aborting with Fault if an ack does not arrive within TIMEOUT cycles.
module change_dispenser #(
  parameter int AMT_W   = 8,
  parameter int CNT_W   = 6,
  parameter int TIMEOUT = 1000
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Req,
  input  logic [AMT_W-1:0] Amount,
  input  logic             LD_INV,
  input  logic [CNT_W-1:0] Inv50,
  input  logic [CNT_W-1:0] Inv100,
  input  logic [CNT_W-1:0] Inv500,
  input  logic [CNT_W-1:0] Inv1000,
  input  logic             CoinIn50,
  input  logic             CoinIn100,
  input  logic             CoinIn500,
  input  logic             CoinIn1000,
  input  logic             HopperAck,
  output logic             DROP50,
  output logic             DROP100,
  output logic             DROP500,
  output logic             DROP1000,
  output logic             Busy,
  output logic             Done,
  output logic             Short,
  output logic             Fault,
  output logic [AMT_W-1:0] ShortAmt,
  output logic [CNT_W-1:0] Cnt50,
  output logic [CNT_W-1:0] Cnt100,
  output logic [CNT_W-1:0] Cnt500,
  output logic [CNT_W-1:0] Cnt1000
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, SEL, DROP, REL, FIN} state_t;

  state_t           state_q, state_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic [AMT_W-1:0] short_amt_q, short_amt_d;
  logic [1:0]       denom_q, denom_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             short_q, short_d;
  logic             fault_q, fault_d;
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];
  logic [CNT_W-1:0] inv_val [4];
  logic [3:0]       coin_in;
  logic [3:0]       dec;
  logic             sel_ok;
  logic [1:0]       sel_den;

  // Denomination index: 0=50, 1=100, 2=500, 3=1000 won.
  function automatic logic [AMT_W-1:0] coin_val(input logic [1:0] d);
    case (d)
      2'd0:    coin_val = AMT_W'(1);
      2'd1:    coin_val = AMT_W'(2);
      2'd2:    coin_val = AMT_W'(10);
      default: coin_val = AMT_W'(20);
    endcase
  endfunction

  assign inv_val[0] = Inv50;
  assign inv_val[1] = Inv100;
  assign inv_val[2] = Inv500;
  assign inv_val[3] = Inv1000;
  assign coin_in    = {CoinIn1000, CoinIn500, CoinIn100, CoinIn50};

  // Ascending scan, so the largest qualifying denomination wins.
  always_comb begin
    sel_ok  = 1'b0;
    sel_den = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (rem_q >= coin_val(2'(i)) && cnt_q[i] != '0) begin
        sel_ok  = 1'b1;
        sel_den = 2'(i);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    denom_d     = denom_q;
    tmo_d       = tmo_q;
    short_d     = short_q;
    fault_d     = fault_q;
    short_amt_d = short_amt_q;
    dec         = '0;
    unique case (state_q)
      IDLE: begin
        if (!LD_INV && Req) begin
          rem_d       = Amount;
          short_d     = 1'b0;
          fault_d     = 1'b0;
          short_amt_d = '0;
          state_d     = SEL;
        end
      end
      SEL: begin
        if (sel_ok) begin
          denom_d = sel_den;
          tmo_d   = '0;
          state_d = DROP;
        end else begin
          // Short/ShortAmt are latched on entry so they are already valid during FIN.
          if (rem_q != '0) begin
            short_d     = 1'b1;
            short_amt_d = rem_q;
          end
          state_d = FIN;
        end
      end
      DROP: begin
        if (HopperAck) begin
          rem_d        = rem_q - coin_val(denom_q);
          dec[denom_q] = 1'b1;
          state_d      = REL;
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          fault_d     = 1'b1;
          short_d     = 1'b1;
          short_amt_d = rem_q;
          state_d     = FIN;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      REL: begin
        if (!HopperAck) state_d = SEL;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
      if (state_q == IDLE && LD_INV) begin
        cnt_d[i] = inv_val[i];
      end else if (coin_in[i] && !dec[i]) begin
        if (cnt_q[i] != '1) cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (dec[i] && !coin_in[i]) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      denom_q     <= '0;
      tmo_q       <= '0;
      short_q     <= 1'b0;
      fault_q     <= 1'b0;
      short_amt_q <= '0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      denom_q     <= denom_d;
      tmo_q       <= tmo_d;
      short_q     <= short_d;
      fault_q     <= fault_d;
      short_amt_q <= short_amt_d;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign DROP50   = (state_q == DROP) && (denom_q == 2'd0);
  assign DROP100  = (state_q == DROP) && (denom_q == 2'd1);
  assign DROP500  = (state_q == DROP) && (denom_q == 2'd2);
  assign DROP1000 = (state_q == DROP) && (denom_q == 2'd3);
  assign Busy     = (state_q != IDLE);
  assign Done     = (state_q == FIN);
  assign Short    = short_q;
  assign Fault    = fault_q;
  assign ShortAmt = short_amt_q;
  assign Cnt50    = cnt_q[0];
  assign Cnt100   = cnt_q[1];
  assign Cnt500   = cnt_q[2];
  assign Cnt1000  = cnt_q[3];

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Sequences the coin hopper when the vending controller returns change. It accepts a change amount in 50-won units and pays it out greedily: 1000 first, then 500, 100 and 50. Each payout is one drop request to the hopper, handshaked and guarded by a timeout. The block keeps per-denomination coin inventories and sits between the control unit's return sequence and the physical hopper.

## Interface
- AMT_W, 8, width of amount and remaining-amount fields (units of 50 won)
- CNT_W, 6, width of each coin inventory counter
- TIMEOUT, 1000, cycles allowed for HopperAck before a fault is declared
- CLK  in  1  system clock; one clock domain, rising edge
- RST  in  1  reset, asynchronous, active-high
- Req  in  1  start payout; sampled only in IDLE
- Amount  in  AMT_W  change to pay, captured when Req is accepted
- LD_INV  in  1  load all four inventories from Inv*; honoured only in IDLE
- Inv50, Inv100, Inv500, Inv1000  in  CNT_W  inventory load values
- CoinIn50, CoinIn100, CoinIn500, CoinIn1000  in  1  one-cycle pulses, each adds a coin to that inventory
- HopperAck  in  1  hopper level acknowledge: high once the coin has dropped, low when the hopper is ready again
- DROP50, DROP100, DROP500, DROP1000  out  1  drop requests, at most one high at a time
- Busy  out  1  high in every state except IDLE
- Done  out  1  one-cycle pulse at the end of each payout
- Short  out  1  last payout was incomplete; held until the next accepted Req
- Fault  out  1  last payout aborted on timeout; held until the next accepted Req
- ShortAmt  out  AMT_W  unpaid remainder of the last payout
- Cnt50, Cnt100, Cnt500, Cnt1000  out  CNT_W  current inventories

## Operation
- Coin values in units: 1000=20, 500=10, 100=2, 50=1. Rem is an AMT_W register.
- FSM states: IDLE, SEL, DROP, REL, FIN. All outputs are Moore, decoded from the state register and the Denom register.
- IDLE:
  - Req=1: Rem<=Amount; clear Short, Fault and ShortAmt; go to SEL.
  - LD_INV has priority over Req. If both are high, LD_INV loads and Req is ignored that cycle.
- SEL:
  - Rem=0: go to FIN.
  - Otherwise pick the largest denomination with value<=Rem and count>0, store it in Denom, clear the timeout counter, go to DROP.
  - No denomination qualifies: go to FIN.
- DROP:
  - The DROP line for Denom is high.
  - HopperAck=1: Rem-=value, count(Denom)-=1, go to REL.
  - Timeout counter reaches TIMEOUT-1 with no ack: Fault<=1, go to FIN. Nothing is decremented.
- REL: all DROP lines low. Wait for HopperAck=0, then go to SEL. REL has no timeout.
- FIN:
  - Done=1 for one cycle.
  - If Rem>0: Short<=1 and ShortAmt<=Rem.
  - Go to IDLE.
- Inventory update per denomination, per cycle, net of simultaneous events:
  - Increment and decrement in the same cycle: count unchanged.
  - Increment alone: saturates at 2^CNT_W-1.
  - A decrement never occurs at 0, because SEL excludes empty denominations.
- CoinIn* is counted in every state.
- Req outside IDLE is ignored. It is not queued.
- Rem cannot underflow, because SEL guarantees value<=Rem.

## Timing
- Reset values:
  - State=IDLE.
  - All DROP lines, Busy, Done, Short and Fault are 0.
  - ShortAmt, Rem, Denom, the timeout counter and all Cnt* are 0.
- RST mid-payout: DROP lines drop asynchronously and inventories clear. Software must reload with LD_INV.
- Req sampled at edge t: Busy=1 and SEL in cycle t+1; first DROP line high in t+2.
- Ack seen at edge a: REL in a+1 with DROP low; Cnt* and Rem updated in a+1.
- Ack falls at edge r: SEL in r+1, next DROP in r+2.
- Amount=0: SEL at t+1, FIN (Done) at t+2, IDLE at t+3.
- Done is high exactly in the FIN cycle. Short, Fault and ShortAmt are valid from that cycle onward.
- Timeout: DROP is held for exactly TIMEOUT cycles, then FIN.
- HopperAck already high on entry to DROP counts as an ack. The bench must keep ack low in IDLE.

## Test plan
- Load all inventories to 10; Req with Amount=33 -> drops in order DROP1000, DROP500, DROP100, DROP50; Done; Short=0; Cnt* = 9,9,9,9.
- Cnt1000=0, Cnt500=10; Amount=40 -> four DROP500; Cnt500=6; Short=0.
- Cnt50=0, Cnt100=1, others 0; Amount=3 -> one DROP100, then FIN with Short=1, ShortAmt=1, Cnt100=0.
- TIMEOUT=16; HopperAck held at 0 -> DROP1000 high for exactly 16 cycles, then Done, Fault=1, Short=1, ShortAmt=Amount, inventories unchanged.
- CoinIn500 pulse in the same cycle the DROP500 ack is taken -> Cnt500 unchanged. CoinIn50 at Cnt50=63 (CNT_W=6) -> stays 63.
- Assert RST while DROP100 is high -> DROP100 low in the same cycle; Busy=0; Cnt*=0. After release, Req is accepted normally.
